// File: rtl/inst_rom_arbiter.sv
// Two-master arbiter in front of a single-port, combinational-read instruction ROM.
// One aligned access takes two cycles (grant, ROM cycle); misaligned requests are answered with err.
module inst_rom_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int FIXED_PRI = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_inst
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t            state_reg;
   state_t            state_next;

   logic [1:0]        req_vec;
   logic [1:0]        ack_vec;
   logic [1:0]        err_vec;
   logic [1:0]        eligible;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] rdata_vec [2];

   logic              last_grant_reg;
   logic              winner_reg;
   logic [ADDR_W-1:0] rom_addr_reg;

   logic              grant_valid;
   logic              grant_id;
   logic [ADDR_W-1:0] grant_addr;
   logic              grant_misaligned;
   logic              grant_take;
   logic              access_done;

   assign req_vec     = {m1_req, m0_req};
   assign req_addr[0] = m0_addr;
   assign req_addr[1] = m1_addr;

   // A master whose ack is on the bus this cycle is not asking for a new word yet.
   assign eligible = req_vec & ~ack_vec;

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (FIXED_PRI != 0) begin
         // m0 holds the ROM while its req line is up, even in its own ack cycle.
         if (eligible[0]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end else if (eligible[1] && !req_vec[0]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
      end else begin
         case (eligible)
            2'b01: begin
               grant_valid = 1'b1;
               grant_id    = 1'b0;
            end
            2'b10: begin
               grant_valid = 1'b1;
               grant_id    = 1'b1;
            end
            2'b11: begin
               grant_valid = 1'b1;
               grant_id    = ~last_grant_reg;
            end
            default: begin
               grant_valid = 1'b0;
               grant_id    = 1'b0;
            end
         endcase
      end
   end

   assign grant_addr       = req_addr[grant_id];
   assign grant_misaligned = |grant_addr[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (grant_valid && !grant_misaligned) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      rom_ce      = 1'b0;
      grant_take  = 1'b0;
      access_done = 1'b0;
      case (state_reg)
         IDLE: begin
            grant_take = grant_valid;
         end
         ACCESS: begin
            rom_ce      = 1'b1;
            access_done = 1'b1;
         end
         default: begin
            rom_ce = 1'b0;
         end
      endcase
   end

   // rom_addr only moves on an aligned grant, so it holds between accesses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_reg <= 1'b1;
         winner_reg     <= 1'b0;
         rom_addr_reg   <= '0;
      end else if (grant_take) begin
         last_grant_reg <= grant_id;
         winner_reg     <= grant_id;
         if (!grant_misaligned) begin
            rom_addr_reg <= grant_addr;
         end
      end
   end

   assign rom_addr = rom_addr_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         localparam logic ID = 1'(gi);

         logic              ack_reg;
         logic              err_reg;
         logic [DATA_W-1:0] rdata_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ack_reg   <= 1'b0;
               err_reg   <= 1'b0;
               rdata_reg <= '0;
            end else begin
               ack_reg <= 1'b0;
               if (access_done && winner_reg == ID) begin
                  ack_reg   <= 1'b1;
                  err_reg   <= 1'b0;
                  rdata_reg <= rom_inst;
               end else if (grant_take && grant_misaligned && grant_id == ID) begin
                  ack_reg   <= 1'b1;
                  err_reg   <= 1'b1;
                  rdata_reg <= '0;
               end
            end
         end

         assign ack_vec[gi]   = ack_reg;
         assign err_vec[gi]   = err_reg;
         assign rdata_vec[gi] = rdata_reg;
      end
   endgenerate

   assign m0_ack   = ack_vec[0];
   assign m0_err   = err_vec[0];
   assign m0_rdata = rdata_vec[0];
   assign m1_ack   = ack_vec[1];
   assign m1_err   = err_vec[1];
   assign m1_rdata = rdata_vec[1];

   a_one_ack : assert property (@(posedge clk) disable iff (!rst) !(m0_ack && m1_ack));
   a_access_one_cycle : assert property (@(posedge clk) disable iff (!rst)
      state_reg == ACCESS |=> state_reg == IDLE);

endmodule
